// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the load-use hazard scoreboard: register file geometry
// and the default load-to-forward latency.
package hazard_scoreboard_pkg;

    localparam int NREG_DEF     = 32;
    localparam int RW_DEF       = 5;
    localparam int LOAD_LAT_DEF = 1;

    function automatic int pend_width(input int lat);
        return $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_pend_counter.sv
// Per-register countdown of cycles until a pending load result becomes
// forwardable; reload wins over decrement, a memory stall freezes the count.
module pend_counter #(
    parameter int W   = 1,
    parameter int LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic freeze,
    output logic pending
);

    logic [W-1:0] cnt_r;

    // Countdown state: load to LAT, hold while frozen, otherwise count down to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (load) begin
            cnt_r <= W'(LAT);
        end else if (freeze) begin
            cnt_r <= cnt_r;
        end else if (cnt_r != '0) begin
            cnt_r <= cnt_r - W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign pending = (cnt_r != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Load-use hazard scoreboard: tracks in-flight load destinations and stalls ID
// while any read source is still waiting on its load result.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NREG     = NREG_DEF,
    parameter int RW       = RW_DEF,
    parameter int NSRC     = 2,
    parameter int LOAD_LAT = LOAD_LAT_DEF,
    parameter int CW       = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               ID_Valid_i,
    input  logic               ID_MemRead_i,
    input  logic [RW-1:0]      ID_Rd_i,
    input  logic [NSRC*RW-1:0] ID_Rs_i,
    input  logic [NSRC-1:0]    ID_RsUse_i,
    input  logic               Mem_Stall_i,
    input  logic               Flush_i,
    output logic               NoOp_EX_o,
    output logic               Stall_ID_o,
    output logic               Busy_o,
    output logic [CW-1:0]      Stall_Cnt_o
);

    localparam int PW    = pend_width(LOAD_LAT);
    localparam int NSLOT = 1 << RW;

    // Slots beyond NREG-1 (non power-of-two register files) and x0 are never pending.
    logic [NSLOT-1:0] pend_s;
    logic             hazard_s;
    logic             issue_s;
    logic [CW-1:0]    stall_cnt_r;

    assign pend_s[0] = 1'b0;

    for (genvar r = 1; r < NSLOT; r++) begin : g_reg
        if (r < NREG) begin : g_cnt
            pend_counter #(
                .W   (PW),
                .LAT (LOAD_LAT)
            ) u_pend (
                .clk     (clk_i),
                .rst     (rst_i),
                .load    (issue_s & ID_MemRead_i & (ID_Rd_i == RW'(r))),
                .freeze  (Mem_Stall_i),
                .pending (pend_s[r])
            );
        end else begin : g_none
            assign pend_s[r] = 1'b0;
        end
    end

    // Hazard when a read, nonzero source still has a load in flight.
    always_comb begin
        hazard_s = 1'b0;
        for (int k = 0; k < NSRC; k++) begin
            hazard_s = hazard_s
                     | (ID_RsUse_i[k]
                        & (ID_Rs_i[k*RW +: RW] != '0)
                        & pend_s[ID_Rs_i[k*RW +: RW]]);
        end
        hazard_s = hazard_s & ID_Valid_i & ~Flush_i;
    end

    assign issue_s    = ID_Valid_i & ~hazard_s & ~Mem_Stall_i & ~Flush_i;
    assign Stall_ID_o = hazard_s;
    assign NoOp_EX_o  = hazard_s & ~Mem_Stall_i;
    assign Busy_o     = |pend_s;

    // Saturating count of bubbles injected into EX.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_r <= '0;
        end else if (NoOp_EX_o && (stall_cnt_r != {CW{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + CW'(1);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign Stall_Cnt_o = stall_cnt_r;

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter NREG, default 32: architectural register count; x0 is hard-wired zero.
REQ-002 Parameter RW, default $clog2(NREG)=5: register index width.
REQ-003 Parameter NSRC, default 2: source operands checked per ID instruction (3 for rs3 formats).
REQ-004 Parameter LOAD_LAT, default 1, range 1..7: cycles after load issue before the result is forwardable.
REQ-005 Parameter CW, default 32: stall performance counter width.
REQ-006 Ports, in order:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous active-high reset.
- ID_Valid_i  in  1  ID holds a real instruction.
- ID_MemRead_i  in  1  ID instruction is a load.
- ID_Rd_i  in  RW  ID destination register.
- ID_Rs_i  in  NSRC*RW  packed sources; source k at bits [k*RW +: RW].
- ID_RsUse_i  in  NSRC  bit k set when source k is read.
- Mem_Stall_i  in  1  memory not ready; whole pipeline frozen.
- Flush_i  in  1  ID instruction squashed (taken branch or jump).
- NoOp_EX_o  out  1  inject bubble into EX.
- Stall_ID_o  out  1  hold PC and IF/ID.
- Busy_o  out  1  any load result still pending.
- Stall_Cnt_o  out  CW  count of injected bubbles.

Function
REQ-007 The block SHALL keep one pending counter, width $clog2(LOAD_LAT+1), for each register 1..NREG-1; register 0 SHALL have no counter and never be pending.
REQ-008 Hazard SHALL be asserted combinationally when ID_Valid_i=1, Flush_i=0, and some k has ID_RsUse_i[k]=1, source k nonzero, and that source's counter nonzero.
REQ-009 Stall_ID_o SHALL equal hazard.
REQ-010 NoOp_EX_o SHALL equal hazard AND NOT Mem_Stall_i.
REQ-011 Issue SHALL be defined as ID_Valid_i & ~hazard & ~Mem_Stall_i & ~Flush_i.
REQ-012 On issue with ID_MemRead_i=1 and ID_Rd_i nonzero, counter[ID_Rd_i] SHALL load LOAD_LAT at the clock edge.
REQ-013 When Mem_Stall_i=0, every nonzero counter not being loaded SHALL decrement by 1 per cycle.
REQ-014 A load to the same register in the same cycle as its decrement SHALL win (reload to LOAD_LAT).
REQ-015 Mem_Stall_i=1 SHALL freeze all counters and block issue; hazard evaluation continues.
REQ-016 Flush_i=1 SHALL suppress hazard, issue and insertion for that cycle, and SHALL leave existing counters decrementing normally.
REQ-017 Non-load instructions SHALL never set counters.
REQ-018 Busy_o SHALL be the OR of all counters being nonzero.
REQ-019 Stall_Cnt_o SHALL increment by 1 on each cycle with NoOp_EX_o=1 and saturate at 2^CW-1.
REQ-020 With LOAD_LAT=1 and NSRC=2, a dependent instruction directly behind a load SHALL see exactly one bubble (classic load-use behaviour).
REQ-021 With LOAD_LAT=L, a dependent instruction directly behind a load SHALL see exactly L bubbles; one with d unrelated instructions in between SHALL see max(L-d,0).

Reset
REQ-022 rst_i=1 SHALL asynchronously clear all counters and Stall_Cnt_o to 0, forcing NoOp_EX_o, Stall_ID_o and Busy_o to 0.
REQ-023 Reset asserted mid-stall SHALL drop the stall immediately; the first post-reset cycle SHALL see no pending registers.

Structure
REQ-024 NREG, RW and the LOAD_LAT default SHALL live in the shared Def.v definitions file; no other constants are shared.
REQ-025 A single sub-module, pend_counter (load/decrement/freeze countdown with async reset), SHALL be instantiated NREG-1 times via generate.

Verification
REQ-026 LOAD_LAT=1: lw x5; add x6,x5,x1 -> one cycle NoOp_EX_o=Stall_ID_o=1, Stall_Cnt_o=1.
REQ-027 LOAD_LAT=3: lw x7; add x8,x0,x7 -> 3 bubbles; with 2 unrelated instructions in between -> 1 bubble.
REQ-028 lw x0 followed by a read of x0, or lw x5 followed by an instruction with ID_RsUse_i=0 on x5 -> no stall, Busy_o=0 after the x0 load.
REQ-029 LOAD_LAT=2: lw x5, dependent in ID, Mem_Stall_i=1 for 4 cycles -> Stall_ID_o=1 and NoOp_EX_o=0 throughout; exactly 2 bubbles after release.
REQ-030 Dependent in ID with Flush_i=1 -> no stall and no bubble counted; back-to-back lw x9 twice -> counter reloads to LOAD_LAT; rst_i pulse mid-stall -> all outputs 0 asynchronously.
